// File: rtl/aes_block_packer.sv
// aes_block_packer: gathers an 8-bit plaintext stream into 16-byte blocks for
// the AES-128 core. It pads a short final block and double-buffers blocks
// (one held at the output, one parked in the accumulator).
module aes_block_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [127:0] blk_data,
  output logic [4:0]   blk_bytes,
  output logic         blk_last
);

  logic [127:0] acc_q, acc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic [4:0]   pend_bytes_q, pend_bytes_d;
  logic         pend_last_q, pend_last_d;
  logic         blk_valid_q, blk_valid_d;
  logic [127:0] blk_data_q, blk_data_d;
  logic [4:0]   blk_bytes_q, blk_bytes_d;
  logic         blk_last_q, blk_last_d;

  logic [127:0] acc_wr;
  logic [127:0] closed_blk;
  logic         byte_acc;
  logic         blk_xfer;
  logic         out_free;
  logic         closes;

  // Input side only depends on registered state (and reset), never on blk_ready.
  assign in_ready  = rst_n && !pend_q;

  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_data_q;
  assign blk_bytes = blk_bytes_q;
  assign blk_last  = blk_last_q;

  assign byte_acc  = in_valid && in_ready;
  assign blk_xfer  = blk_valid_q && blk_ready;
  assign out_free  = !blk_valid_q || blk_ready;
  assign closes    = byte_acc && ((cnt_q == 4'hf) || in_last);

  // Lane insert of the current byte; the closed view also pads every higher lane.
  always_comb begin
    acc_wr     = acc_q;
    closed_blk = acc_q;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) == cnt_q) begin
        acc_wr[127-8*i -: 8]     = in_data;
        closed_blk[127-8*i -: 8] = in_data;
      end else if (4'(i) > cnt_q) begin
        closed_blk[127-8*i -: 8] = PAD_BYTE;
      end
    end
  end

  // Next-state: accumulate, close, park or load the output register.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_bytes_d = pend_bytes_q;
    pend_last_d  = pend_last_q;
    blk_valid_d  = blk_valid_q;
    blk_data_d   = blk_data_q;
    blk_bytes_d  = blk_bytes_q;
    blk_last_d   = blk_last_q;

    // A transfer empties the output unless something reloads it below.
    if (blk_xfer) begin
      blk_valid_d = 1'b0;
    end

    if (pend_q) begin
      // Parked block moves to the output as soon as the held one leaves.
      if (blk_xfer) begin
        blk_valid_d = 1'b1;
        blk_data_d  = acc_q;
        blk_bytes_d = pend_bytes_q;
        blk_last_d  = pend_last_q;
        pend_d      = 1'b0;
        cnt_d       = 4'd0;
      end
    end else if (byte_acc) begin
      if (closes) begin
        if (out_free) begin
          blk_valid_d = 1'b1;
          blk_data_d  = closed_blk;
          blk_bytes_d = {1'b0, cnt_q} + 5'd1;
          blk_last_d  = in_last;
          cnt_d       = 4'd0;
        end else begin
          acc_d        = closed_blk;
          pend_d       = 1'b1;
          pend_bytes_d = {1'b0, cnt_q} + 5'd1;
          pend_last_d  = in_last;
        end
      end else begin
        acc_d = acc_wr;
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Control and output registers; reset discards any partial or parked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= 4'd0;
      pend_q       <= 1'b0;
      pend_bytes_q <= 5'd0;
      pend_last_q  <= 1'b0;
      blk_valid_q  <= 1'b0;
      blk_data_q   <= 128'd0;
      blk_bytes_q  <= 5'd0;
      blk_last_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_bytes_q <= pend_bytes_d;
      pend_last_q  <= pend_last_d;
      blk_valid_q  <= blk_valid_d;
      blk_data_q   <= blk_data_d;
      blk_bytes_q  <= blk_bytes_d;
      blk_last_q   <= blk_last_d;
    end
  end

  // Accumulator data needs no reset: cnt_q decides which lanes are meaningful.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Testbench for aes_block_packer: table-driven vectors, hand-written
// backpressure / collision / reset sequences and a randomised scoreboard run.
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [4:0]   blk_bytes;
  logic         blk_last;

  logic         in_ready5;
  logic         blk_valid5;
  logic [127:0] blk_data5;
  logic [4:0]   blk_bytes5;
  logic         blk_last5;

  int n_total = 0;
  int n_pass  = 0;

  aes_block_packer #(.PAD_BYTE(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_bytes(blk_bytes), .blk_last(blk_last)
  );

  aes_block_packer #(.PAD_BYTE(8'h5a)) u_dut5a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data), .in_last(in_last),
    .blk_valid(blk_valid5), .blk_ready(blk_ready), .blk_data(blk_data5),
    .blk_bytes(blk_bytes5), .blk_last(blk_last5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [7:0]   d;
    logic         l;
    logic         ev;
    logic [127:0] edata;
    logic [4:0]   eb;
    logic         el;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } sbyte_t;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   bytes;
    logic         last;
  } blk_t;

  vec_t   vec [27];
  sbyte_t stream [$];
  blk_t   exp_q [$];

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic l,
                              input logic ev, input logic [127:0] edata,
                              input logic [4:0] eb, input logic el);
    vec_t v;
    v.iv = iv; v.d = d; v.l = l; v.ev = ev; v.edata = edata; v.eb = eb; v.el = el;
    return v;
  endfunction

  // 16 consecutive byte values starting at s, first byte in the top lane.
  function automatic logic [127:0] seq_blk(input logic [7:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s + 8'(i);
    return r;
  endfunction

  // Replace every lane at or beyond 'bytes' with the pad value.
  function automatic logic [127:0] pad_fill(input logic [127:0] d, input logic [4:0] bytes,
                                            input logic [7:0] pad);
    logic [127:0] r;
    r = d;
    for (int i = 0; i < 16; i++) if (i >= int'(bytes)) r[127-8*i -: 8] = pad;
    return r;
  endfunction

  // Drive one cycle of inputs (called at a negedge) and advance to the next negedge.
  task automatic step(input logic iv, input logic [7:0] d, input logic l, input logic br);
    in_valid  = iv;
    in_data   = d;
    in_last   = l;
    blk_ready = br;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [127:0] snap_data;
  logic [4:0]   snap_bytes;
  logic         snap_last;
  logic         held;
  logic         br;
  logic         iv;
  logic         acc;
  int           idx;
  int           cycles;
  int           nblk;
  logic [127:0] got;
  logic [127:0] buf_d;
  int           bcnt;
  int           len;
  blk_t         eb;
  sbyte_t       sb;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; blk_ready = 1'b0;

    // ---------------- reset state ----------------
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_data", blk_data, 0);
    check("rst_blk_bytes", blk_bytes, 0);
    check("rst_blk_last", blk_last, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // ---------------- table-driven vectors ----------------
    for (int k = 0; k < 16; k++) vec[k] = mk(1'b1, 8'(k), 1'b0, 1'b0, 128'd0, 5'd0, 1'b0);
    vec[16] = mk(1'b0, 8'h00, 1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 5'd16, 1'b0);
    vec[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 128'd0, 5'd0, 1'b0);
    vec[18] = mk(1'b1, 8'haa, 1'b0, 1'b0, 128'd0, 5'd0, 1'b0);
    vec[19] = mk(1'b1, 8'hbb, 1'b0, 1'b0, 128'd0, 5'd0, 1'b0);
    vec[20] = mk(1'b1, 8'hcc, 1'b1, 1'b0, 128'd0, 5'd0, 1'b0);
    vec[21] = mk(1'b0, 8'h00, 1'b0, 1'b1, 128'haabbcc00_00000000_00000000_00000000, 5'd3, 1'b1);
    vec[22] = mk(1'b1, 8'h11, 1'b1, 1'b0, 128'd0, 5'd0, 1'b0);
    vec[23] = mk(1'b1, 8'h22, 1'b1, 1'b1, 128'h11000000_00000000_00000000_00000000, 5'd1, 1'b1);
    vec[24] = mk(1'b1, 8'h33, 1'b1, 1'b1, 128'h22000000_00000000_00000000_00000000, 5'd1, 1'b1);
    vec[25] = mk(1'b0, 8'h00, 1'b0, 1'b1, 128'h33000000_00000000_00000000_00000000, 5'd1, 1'b1);
    vec[26] = mk(1'b0, 8'h00, 1'b0, 1'b0, 128'd0, 5'd0, 1'b0);

    for (int k = 0; k < 27; k++) begin
      check($sformatf("vec%0d_in_ready", k), in_ready, 1);
      check($sformatf("vec%0d_blk_valid", k), blk_valid, vec[k].ev);
      if (vec[k].ev) begin
        check($sformatf("vec%0d_blk_data", k), blk_data, vec[k].edata);
        check($sformatf("vec%0d_blk_bytes", k), blk_bytes, vec[k].eb);
        check($sformatf("vec%0d_blk_last", k), blk_last, vec[k].el);
        check($sformatf("vec%0d_pad5a_data", k), blk_data5,
              pad_fill(vec[k].edata, vec[k].eb, 8'h5a));
      end
      step(vec[k].iv, vec[k].d, vec[k].l, 1'b1);
    end

    // ---------------- backpressure: 32 bytes with blk_ready low ----------------
    for (int k = 0; k < 32; k++) begin
      check($sformatf("bp_in_ready%0d", k), in_ready, 1);
      if (k >= 16) check($sformatf("bp_stable%0d", k), {blk_valid, blk_data}, {1'b1, seq_blk(8'h00)});
      step(1'b1, 8'(k), 1'b0, 1'b0);
    end
    check("bp_in_ready_drop", in_ready, 0);
    check("bp_first_held", {blk_valid, blk_data}, {1'b1, seq_blk(8'h00)});
    step(1'b1, 8'hee, 1'b1, 1'b1);
    check("bp_second_valid", blk_valid, 1);
    check("bp_second_data", blk_data, seq_blk(8'h10));
    check("bp_second_bytes", blk_bytes, 16);
    check("bp_in_ready_back", in_ready, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("bp_drained", blk_valid, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("bp_ignored_byte", blk_valid, 0);

    // ---------------- close/drain collision ----------------
    for (int k = 0; k < 16; k++) step(1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("col_in_ready%0d", k), in_ready, 1);
      check($sformatf("col_a_held%0d", k), {blk_valid, blk_data}, {1'b1, seq_blk(8'h40)});
      step(1'b1, 8'h50 + 8'(k), 1'b0, (k == 15));
    end
    check("col_b_valid", blk_valid, 1);
    check("col_b_data", blk_data, seq_blk(8'h50));
    check("col_no_pend", in_ready, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("col_drained", blk_valid, 0);

    // ---------------- reset mid-block ----------------
    for (int k = 0; k < 5; k++) step(1'b1, 8'h90 + 8'(k), 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b1;
    nblk = 0;
    got  = 128'd0;
    for (int k = 0; k < 20; k++) begin
      if (blk_valid) begin
        nblk++;
        got = blk_data;
      end
      if (k < 16) step(1'b1, 8'h20 + 8'(k), 1'b0, 1'b1);
      else        step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    check("mid_rst_block_count", nblk, 1);
    check("mid_rst_block_data", got, seq_blk(8'h20));

    // ---------------- random gaps and backpressure, 1000 messages ----------------
    for (int m = 0; m < 1000; m++) begin
      len   = $urandom_range(1, 64);
      buf_d = 128'd0;
      bcnt  = 0;
      for (int j = 0; j < len; j++) begin
        sb.d = 8'($urandom);
        sb.l = (j == len - 1);
        stream.push_back(sb);
        buf_d[127-8*bcnt -: 8] = sb.d;
        bcnt++;
        if (bcnt == 16 || sb.l) begin
          eb.data  = buf_d;
          eb.bytes = 5'(bcnt);
          eb.last  = sb.l;
          exp_q.push_back(eb);
          buf_d = 128'd0;
          bcnt  = 0;
        end
      end
    end

    idx    = 0;
    cycles = 0;
    held   = 1'b0;
    snap_data = 128'd0; snap_bytes = 5'd0; snap_last = 1'b0;
    while ((idx < stream.size() || exp_q.size() > 0 || blk_valid) && cycles < 90000) begin
      br = ($urandom_range(0, 3) != 0);
      if (held)
        check("rnd_stable", {blk_valid, blk_data, blk_bytes, blk_last},
              {1'b1, snap_data, snap_bytes, snap_last});
      if (blk_valid && br) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_block", blk_valid, 0);
        end else begin
          eb = exp_q.pop_front();
          check("rnd_block", {blk_data, blk_bytes, blk_last}, {eb.data, eb.bytes, eb.last});
        end
      end
      held = blk_valid && !br;
      snap_data = blk_data; snap_bytes = blk_bytes; snap_last = blk_last;
      iv  = (idx < stream.size()) && ($urandom_range(0, 3) != 0);
      acc = iv && in_ready;
      if (iv) step(1'b1, stream[idx].d, stream[idx].l, br);
      else    step(1'b0, 8'($urandom), 1'($urandom), br);
      if (acc) idx++;
      cycles++;
    end
    check("rnd_all_bytes_sent", idx, stream.size());
    check("rnd_all_blocks_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Byte-stream to 128-bit block packer that sits directly upstream of the unrolled AES-128 encryption core. It gathers an 8-bit input stream into 16-byte blocks and pads a short final block. It presents each block on a registered, stable valid/ready interface, so the combinational cipher datapath sees a constant plaintext for as long as the consumer needs. It is double-buffered: one block can wait in the accumulator while the previous block is held at the output.

## Interface
- PAD_BYTE, 8'h00, fill value for unused byte lanes of a short final block

- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  in_data/in_last valid this cycle
- in_ready  output  1  packer can accept a byte this cycle
- in_data  input  8  plaintext byte
- in_last  input  1  marks final byte of a message; qualified by in_valid
- blk_valid  output  1  blk_* outputs hold a complete block
- blk_ready  input  1  consumer (cipher core capture) takes the block this cycle
- blk_data  output  128  plaintext block; first byte of the block in [127:120], 16th in [7:0]
- blk_bytes  output  5  count of real (non-pad) bytes, 1..16
- blk_last  output  1  block closed by in_last

## Operation
- A byte transfer occurs when in_valid && in_ready. A block transfer occurs when blk_valid && blk_ready.
- Accumulator: 128-bit register, 4-bit byte count cnt (0..15), flag pend.
  - Each accepted byte is written to lane cnt, with lane 0 = [127:120].
  - The byte closes the block if cnt==15 or in_last==1.
- Closing a block:
  - Block content = accumulated bytes, the current byte, and PAD_BYTE in every higher lane.
  - blk_bytes = cnt+1. blk_last = in_last.
- Output register free = !blk_valid, or a block transfer in the same cycle.
- If the output register is free when a block closes:
  - The closed block is loaded into blk_data/blk_bytes/blk_last and blk_valid=1 at that edge.
  - cnt returns to 0.
- If the output register is not free:
  - The closed block is parked in the accumulator and pend=1.
- While pend=1:
  - in_ready=0.
  - On the next block transfer, the parked block loads into the output register at that edge. pend and cnt clear at the same edge.
- in_ready = !pend. This is a registered-state function only, with no combinational path from blk_ready.
- blk_* outputs stay stable while blk_valid && !blk_ready.
  - blk_valid falls only on a transfer with nothing to reload.
- in_last with cnt==15 produces a full block with blk_bytes=16 and blk_last=1.
- An empty message cannot be expressed; in_last always qualifies a byte.
- in_data and in_last are ignored when in_ready=0 or in_valid=0. in_valid gaps inside a block are allowed and do not alter content.

## Timing
- Reset (rst_n=0 at a rising edge):
  - Clears cnt, pend, blk_valid, blk_data, blk_bytes and blk_last to 0.
  - Any partial or parked block is discarded and never emitted.
  - in_ready = 1 from the first cycle after reset. in_ready is held 0 while rst_n=0.
- Latency: the closing byte is accepted at edge N; blk_valid=1 in the cycle after edge N.
- Throughput: with blk_ready held 1, one byte per cycle sustained with no bubbles.
  - This gives one block every 16 cycles, and every cycle for 1-byte messages.
- Simultaneous block close and block transfer at the same edge:
  - The new block replaces the outgoing one.
  - blk_valid stays 1 and pend stays 0.
- With pend=1 and blk_ready asserted, the parked block appears in the cycle after the transfer edge. in_ready returns to 1 in that same cycle.
- Worst-case storage: 2 blocks (output + parked). No byte is ever dropped or duplicated.

## Test plan
- Contiguous bytes 8'h00..8'h0f, blk_ready=1 -> one cycle after the 16th byte:
  - blk_valid=1, blk_data=128'h000102030405060708090a0b0c0d0e0f, blk_bytes=16, blk_last=0.
  - Valid for exactly one cycle. in_ready never drops.
- Short message: bytes aa, bb, cc with in_last on cc, PAD_BYTE=8'h00:
  - blk_data=128'haabbcc00_00000000_00000000_00000000, blk_bytes=3, blk_last=1.
  - Repeat with PAD_BYTE=8'h5a: the 13 pad lanes = 8'h5a.
- Backpressure: blk_ready=0 while sending 32 bytes 00..1f:
  - First block stays stable.
  - in_ready drops the cycle after byte 1f is accepted.
  - Raise blk_ready: the first block transfers, then the second block (10..1f) appears the next cycle, and in_ready=1 that same cycle.
- Close/drain collision: block A held with blk_ready=0; raise blk_ready in the same cycle block B's 16th byte is accepted:
  - A transfers, B visible the next cycle, pend never set.
- Reset mid-block: 5 bytes accepted, rst_n=0 for one cycle, then 16 bytes 20..2f:
  - Exactly one block, 128'h202122...2f. No block emitted from the 5 discarded bytes.
- Random in_valid gaps and random blk_ready, 1000 messages of length 1..64:
  - Scoreboard matches all bytes, padding, blk_bytes and blk_last.
  - Stability is checked whenever blk_valid && !blk_ready.
